line_cmd_dispatcher: RTL and testbench
======================================

LINE_CMD_DISPATCHER -- requirements
Module: line_cmd_dispatcher

Interface
REQ-001 The block SHALL have parameter WIDTH, default 13, the coordinate width in bits, matching the line-drawing core.
REQ-002 The block SHALL have parameter DEPTH, default 4, the number of command FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: the upstream command is present.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the FIFO can accept a command this cycle.
REQ-007 The block SHALL have ports cmd_x0, cmd_y0, cmd_x1, cmd_y1, each input, WIDTH bits: the endpoints of the offered line.
REQ-008 The block SHALL have port cmd_flush, input, 1 bit: discard all queued, undispatched commands.
REQ-009 The block SHALL have port start, output, 1 bit: a one-cycle launch pulse to the line-drawing core.
REQ-010 The block SHALL have ports x0, y0, x1, y1, each output, WIDTH bits: the registered endpoints driven to the core.
REQ-011 The block SHALL have port sys_finish, input, 1 bit: the line-drawing core's completion indication.
REQ-012 The block SHALL have port busy, output, 1 bit: a line is in flight (state is not IDLE).
REQ-013 The block SHALL have port lines_done, output, 16 bits: the count of completed lines.

Function
REQ-014 A command SHALL be pushed when cmd_valid && cmd_ready; cmd_ready SHALL be 1 exactly when FIFO occupancy < DEPTH.
REQ-015 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, RELEASE.
REQ-016 In IDLE with the FIFO non-empty and cmd_flush low, the block SHALL pop the head, load it into x0/y0/x1/y1 and go to LAUNCH.
REQ-017 LAUNCH SHALL assert start for exactly one cycle, then go to WAIT; dispatch latency from push into an empty FIFO to start high SHALL be 2 cycles.
REQ-018 WAIT SHALL hold until a cycle with sys_finish=1, increment lines_done (wrapping 0xFFFF to 0), then go to RELEASE.
REQ-019 RELEASE SHALL hold until sys_finish=0, then go to IDLE; no new start SHALL be issued while sys_finish is high.
REQ-020 x0/y0/x1/y1 SHALL stay constant from LAUNCH until the block next leaves IDLE.
REQ-021 A sys_finish pulse in IDLE or LAUNCH SHALL be ignored.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged; occupancy SHALL never exceed DEPTH or underflow.
REQ-023 cmd_flush SHALL empty the FIFO in one cycle, override a same-cycle push, and inhibit a same-cycle IDLE pop; it SHALL not affect an in-flight line.
REQ-024 Coordinates SHALL pass through unmodified, with no clipping or reordering; degenerate lines (x0=x1, y0=y1) SHALL be dispatched normally.

Reset
REQ-025 Asserting reset SHALL immediately clear the state to IDLE, the FIFO to empty, start to 0, x0/y0/x1/y1 to 0, lines_done to 0 and busy to 0.
REQ-026 Reset asserted mid-line SHALL abandon the line without a further start; the core is reset by the same signal.
REQ-027 After reset deasserts, cmd_ready SHALL be 1 in the first cycle.

Structure
REQ-028 The WIDTH and DEPTH defaults and the FSM state encodings SHALL live in the shared line-drawing package or include file.
REQ-029 The FIFO SHALL be a sub-module, line_cmd_fifo: a synchronous FIFO storing {x0,y0,x1,y1} with flush, full and empty outputs.

Verification
REQ-030 After reset, push (10,20,100,50) -> start high exactly at cycle 2 after push, x0=10 y0=20 x1=100 y1=50; sys_finish high 1 cycle then low -> lines_done=1, busy=0.
REQ-031 Push 5 commands back-to-back while the core is held busy (sys_finish=0) -> first dispatched, 4 queued, cmd_ready=0 on the 6th offer; the 6th command is not accepted.
REQ-032 Hold sys_finish high for 5 cycles after completion with the FIFO non-empty -> no start until 1 cycle after sys_finish falls; lines_done increments once.
REQ-033 Queue 3 commands, assert cmd_flush during WAIT -> in-flight line completes, no further start, occupancy 0.
REQ-034 Assert reset during WAIT with 2 queued -> start=0, outputs 0, cmd_ready=1, lines_done=0; no start after release.
REQ-035 Preload lines_done=0xFFFF by running 65535 lines (or force) then complete one more -> lines_done=0x0000.

Source files
------------

// File: rtl/line_cmd_dispatcher_pkg.sv
// Shared line-drawing definitions: coordinate/queue defaults and the
// dispatcher FSM state encoding.
package line_cmd_dispatcher_pkg;

  localparam int LINE_WIDTH   = 13;
  localparam int LINE_DEPTH   = 4;
  localparam int LINES_DONE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } line_state_e;

  // Number of bits in one queued command {x0,y0,x1,y1}.
  function automatic int cmd_bits(input int width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/line_cmd_dispatcher_fifo.sv
// Synchronous command FIFO holding {x0,y0,x1,y1}; flush empties it in one
// cycle and wins over a same-cycle push or pop.
module line_cmd_fifo
  import line_cmd_dispatcher_pkg::*;
#(
  parameter int WIDTH = LINE_WIDTH,
  parameter int DEPTH = LINE_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [cmd_bits(WIDTH)-1:0]   i_data,
  output logic [cmd_bits(WIDTH)-1:0]   o_data,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = cmd_bits(WIDTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full  && !i_flush;
  assign w_pop   = i_pop  && !o_empty && !i_flush;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy decides validity,
  // and leaving it out of reset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/line_cmd_dispatcher.sv
// Queues line commands and launches them one at a time into the
// line-drawing core, handshaking on its sys_finish indication.
module line_cmd_dispatcher
  import line_cmd_dispatcher_pkg::*;
#(
  parameter int WIDTH = LINE_WIDTH,
  parameter int DEPTH = LINE_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [WIDTH-1:0]        cmd_x0,
  input  logic [WIDTH-1:0]        cmd_y0,
  input  logic [WIDTH-1:0]        cmd_x1,
  input  logic [WIDTH-1:0]        cmd_y1,
  input  logic                    cmd_flush,
  output logic                    start,
  output logic [WIDTH-1:0]        x0,
  output logic [WIDTH-1:0]        y0,
  output logic [WIDTH-1:0]        x1,
  output logic [WIDTH-1:0]        y1,
  input  logic                    sys_finish,
  output logic                    busy,
  output logic [LINES_DONE_W-1:0] lines_done
);

  line_state_e             r_state;
  logic                    r_start;
  logic [WIDTH-1:0]        r_x0;
  logic [WIDTH-1:0]        r_y0;
  logic [WIDTH-1:0]        r_x1;
  logic [WIDTH-1:0]        r_y1;
  logic [LINES_DONE_W-1:0] r_lines_done;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_pop;
  logic [cmd_bits(WIDTH)-1:0] w_head;

  // A flush in the same cycle discards the head rather than dispatching it.
  assign w_pop = (r_state == S_IDLE) && !w_empty && !cmd_flush;

  line_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_pop   (w_pop),
    .i_flush (cmd_flush),
    .i_data  ({cmd_x0, cmd_y0, cmd_x1, cmd_y1}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start      <= 1'b0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_lines_done <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_x0, r_y0, r_x1, r_y1} <= w_head;
            r_state                  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (sys_finish) begin
            r_lines_done <= r_lines_done + 1'b1;
            r_state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Wait for the core to drop finish so one completion is never
          // counted twice or overlapped with the next launch.
          if (!sys_finish) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign start      = r_start;
  assign x0         = r_x0;
  assign y0         = r_y0;
  assign x1         = r_x1;
  assign y1         = r_y1;
  assign busy       = (r_state != S_IDLE);
  assign lines_done = r_lines_done;

endmodule

// File: tb/tb_line_cmd_dispatcher.sv
// Directed bench for line_cmd_dispatcher with a coordinate scoreboard.
module tb_line_cmd_dispatcher;
  import line_cmd_dispatcher_pkg::*;

  localparam int W  = LINE_WIDTH;
  localparam int D  = LINE_DEPTH;
  localparam int CW = 4 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_flush = 1'b0;
  logic          sys_finish = 1'b0;
  logic [W-1:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic          cmd_ready, start, busy;
  logic [W-1:0]  x0, y0, x1, y1;
  logic [15:0]   lines_done;

  int            total = 0;
  int            bad = 0;
  int            n_started = 0;
  int            n_finished = 0;
  int            base;
  logic [15:0]   exp_lines = '0;
  logic [CW-1:0] sb [$];

  line_cmd_dispatcher #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_flush  (cmd_flush),
    .start      (start),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .sys_finish (sys_finish),
    .busy       (busy),
    .lines_done (lines_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every start must match the oldest accepted, still-queued command.
  always @(negedge clk) begin
    if (!reset && start === 1'b1) begin : mon
      logic [CW-1:0] e;
      n_started++;
      if (sb.size() == 0) begin
        check("spurious_start", 64'(start), 64'd0);
      end else begin
        e = sb.pop_front();
        check("dispatch_coords", 64'({x0, y0, x1, y1}), 64'(e));
      end
    end
  end

  task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d,
                          input logic exp_acc);
    cmd_valid = 1'b1;
    cmd_x0 = a; cmd_y0 = b; cmd_x1 = c; cmd_y1 = d;
    check("cmd_ready_on_offer", 64'(cmd_ready), 64'(exp_acc));
    if (exp_acc) sb.push_back({a, b, c, d});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_in_flight();
    int k = 0;
    while (!(n_started > n_finished && start === 1'b0 && busy === 1'b1) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("line_in_flight_within_bound", 64'(k < 20), 64'd1);
  endtask

  task automatic finish_line();
    wait_in_flight();
    sys_finish = 1'b1;
    @(posedge clk); #1;
    exp_lines++;
    check("lines_done", 64'(lines_done), 64'(exp_lines));
    sys_finish = 1'b0;
    @(posedge clk); #1;
    n_finished++;
    check("busy_after_release", 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_start", 64'(start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_lines_done", 64'(lines_done), 64'd0);
    check("rst_coords", 64'({x0, y0, x1, y1}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Basic dispatch with 2-cycle latency
    push_cmd(13'd10, 13'd20, 13'd100, 13'd50, 1'b1);
    check("t1_start_edge0", 64'(start), 64'd0);
    @(posedge clk); #1;
    check("t1_start_edge1", 64'(start), 64'd0);
    check("t1_busy_edge1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("t1_start_edge2", 64'(start), 64'd1);
    check("t1_x0", 64'(x0), 64'd10);
    check("t1_y0", 64'(y0), 64'd20);
    check("t1_x1", 64'(x1), 64'd100);
    check("t1_y1", 64'(y1), 64'd50);
    finish_line();

    // Fill the FIFO while the core is busy; the sixth offer is refused
    base = n_started;
    push_cmd(13'd1, 13'd2, 13'd3, 13'd4, 1'b1);
    push_cmd(13'd11, 13'd12, 13'd13, 13'd14, 1'b1);
    push_cmd(13'd21, 13'd22, 13'd23, 13'd24, 1'b1);
    push_cmd(13'h1FFF, 13'd0, 13'd0, 13'h1FFF, 1'b1);
    push_cmd(13'd41, 13'd42, 13'd43, 13'd44, 1'b1);
    push_cmd(13'd51, 13'd52, 13'd53, 13'd54, 1'b0);
    check("t2_one_dispatched", 64'(n_started - base), 64'd1);
    check("t2_still_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 5; i++) finish_line();
    check("t2_queue_drained", 64'(sb.size()), 64'd0);

    // Finish held high: no relaunch until it falls, one increment only
    push_cmd(13'd300, 13'd301, 13'd302, 13'd303, 1'b1);
    push_cmd(13'd7, 13'd7, 13'd7, 13'd7, 1'b1);
    wait_in_flight();
    base = n_started;
    sys_finish = 1'b1;
    exp_lines++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t3_no_start_while_finish", 64'(start), 64'd0);
      check("t3_lines_once", 64'(lines_done), 64'(exp_lines));
    end
    sys_finish = 1'b0;
    @(posedge clk); #1;
    n_finished++;
    check("t3_idle_after_fall", 64'(busy), 64'd0);
    check("t3_no_start_after_fall", 64'(n_started - base), 64'd0);
    finish_line();

    // Flush during WAIT, with a same-cycle push that must be dropped
    push_cmd(13'd61, 13'd62, 13'd63, 13'd64, 1'b1);
    push_cmd(13'd71, 13'd72, 13'd73, 13'd74, 1'b1);
    push_cmd(13'd81, 13'd82, 13'd83, 13'd84, 1'b1);
    push_cmd(13'd91, 13'd92, 13'd93, 13'd94, 1'b1);
    wait_in_flight();
    cmd_flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_x0 = 13'd99; cmd_y0 = 13'd99; cmd_x1 = 13'd99; cmd_y1 = 13'd99;
    @(posedge clk); #1;
    cmd_flush = 1'b0;
    cmd_valid = 1'b0;
    while (sb.size() > 0) void'(sb.pop_back());
    check("t4_inflight_kept", 64'(busy), 64'd1);
    base = n_started;
    finish_line();
    repeat (10) @(posedge clk);
    #1;
    check("t4_no_start_after_flush", 64'(n_started - base), 64'd0);
    check("t4_idle", 64'(busy), 64'd0);

    // Reset in WAIT with two queued
    push_cmd(13'd5, 13'd6, 13'd7, 13'd8, 1'b1);
    push_cmd(13'd15, 13'd16, 13'd17, 13'd18, 1'b1);
    push_cmd(13'd25, 13'd26, 13'd27, 13'd28, 1'b1);
    wait_in_flight();
    #2;
    reset = 1'b1;
    #1;
    check("t5_start", 64'(start), 64'd0);
    check("t5_coords", 64'({x0, y0, x1, y1}), 64'd0);
    check("t5_lines_done", 64'(lines_done), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_cmd_ready", 64'(cmd_ready), 64'd1);
    while (sb.size() > 0) void'(sb.pop_back());
    n_started = 0;
    n_finished = 0;
    exp_lines = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_ready_first_cycle", 64'(cmd_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check("t5_no_start_after_reset", 64'(n_started), 64'd0);
    push_cmd(13'd1, 13'd1, 13'd2, 13'd2, 1'b1);
    finish_line();

    // lines_done wraps from 0xFFFF to 0
    force dut.r_lines_done = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_lines_done;
    exp_lines = 16'hFFFF;
    check("t6_preload", 64'(lines_done), 64'hFFFF);
    push_cmd(13'd4, 13'd3, 13'd2, 13'd1, 1'b1);
    finish_line();
    check("t6_wrapped", 64'(lines_done), 64'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
